sobel_edge_stream: RTL and testbench

//   Parametrised streaming 3x3 Sobel edge detector for raster-order pixel

---
 rtl/sobel_edge_stream.sv | 99 +++++++++
 tb/tb_sobel_edge_stream.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector, magnitude or binary-threshold output
// Ports: clk, rst (async, active-high); in_valid/in_sof/pixel_in raster input;
//        mode (0 magnitude, 1 threshold), threshold; out_valid/out_sof/out_eol/edge_out result.
module sobel_edge_stream #(
  parameter int PIX_W      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic [PIX_W-1:0] edge_out
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 3;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  logic [CW-1:0]    r_col, w_col;
  logic [RW-1:0]    r_row, w_row;
  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_win [3][3];
  logic [GW-1:0]    w_ext [3][3];
  logic [GW-1:0]    w_gx, w_gy, r_gx, r_gy, w_ax, w_ay, w_mag;
  logic [PIX_W-1:0] w_sat, w_edge, r_edge;
  logic             w_sof, w_hit, r_v0, r_s0, r_e0, r_v1, r_s1, r_e1, r_ov, r_os, r_oe;
  // A valid sof beat forces position (0,0) regardless of the counters.
  assign w_sof = in_valid & in_sof;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;
  assign w_hit = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      r_col <= (w_col == C_LAST) ? '0 : w_col + 1'b1;
      r_row <= (w_col != C_LAST) ? w_row : (w_row == R_LAST) ? '0 : w_row + 1'b1;
    end
  // Line buffers and window are data only; validity is carried by the r_v* pipeline.
  // Row 0 of the window is the oldest line (lb0), row 2 the incoming pixel.
  always_ff @(posedge clk)
    if (in_valid) begin
      r_lb0[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= pixel_in;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= r_lb0[w_col];
      r_win[1][2] <= r_lb1[w_col];
      r_win[2][2] <= pixel_in;
    end
  // Gradients use modulo-2^GW arithmetic, which is exact two's complement here.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_ext[i][j] = GW'(r_win[i][j]);
    w_gx = (w_ext[0][2] + (w_ext[1][2] << 1) + w_ext[2][2]) - (w_ext[0][0] + (w_ext[1][0] << 1) + w_ext[2][0]);
    w_gy = (w_ext[2][0] + (w_ext[2][1] << 1) + w_ext[2][2]) - (w_ext[0][0] + (w_ext[0][1] << 1) + w_ext[0][2]);
    w_ax = r_gx[GW-1] ? -r_gx : r_gx;
    w_ay = r_gy[GW-1] ? -r_gy : r_gy;
    w_mag = w_ax + w_ay;
    w_sat = |w_mag[GW-1:PIX_W] ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];
    w_edge = mode ? {PIX_W{w_sat >= threshold}} : w_sat;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_v0, r_s0, r_e0, r_v1, r_s1, r_e1, r_ov, r_os, r_oe} <= '0;
      r_gx   <= '0;
      r_gy   <= '0;
      r_edge <= '0;
    end else begin
      r_v0   <= w_hit;
      r_s0   <= w_hit && (w_row == RW'(2)) && (w_col == CW'(2));
      r_e0   <= w_hit && (w_col == C_LAST);
      r_v1   <= r_v0;
      r_s1   <= r_s0;
      r_e1   <= r_e0;
      r_gx   <= w_gx;
      r_gy   <= w_gy;
      r_ov   <= r_v1;
      r_os   <= r_s1;
      r_oe   <= r_e1;
      r_edge <= r_v1 ? w_edge : '0;
    end
  assign out_valid = r_ov;
  assign out_sof   = r_os;
  assign out_eol   = r_oe;
  assign edge_out  = r_edge;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: scoreboard bench for sobel_edge_stream on a 5x5 image
module tb_sobel_edge_stream;
  localparam int W = 5;
  localparam int H = 5;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0, mode = 0;
  logic [7:0] pixel_in = 0, threshold = 0;
  logic out_valid, out_sof, out_eol;
  logic [7:0] edge_out;
  typedef struct {logic [7:0] e; logic s; logic l; int t;} exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0, rx = 0, mr = 0, mc = 0, base = 0;
  int img [H][W];
  logic [7:0] last_e = 0;
  sobel_edge_stream #(.PIX_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .pixel_in(pixel_in),
    .mode(mode), .threshold(threshold), .out_valid(out_valid), .out_sof(out_sof),
    .out_eol(out_eol), .edge_out(edge_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [7:0] pix(input int pat, input int c);
    return pat == 0 ? 8'h40 : pat == 1 ? (c < 2 ? 8'h00 : 8'hFF) : 8'(10 * c);
  endfunction
  // Drives one cycle; valid beats update a full-frame reference image and
  // push the expected result, due 3 negedges later (2 clocks after sampling).
  task automatic beat(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    pixel_in = p;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        int gx, gy, m;
        exp_t x;
        gx = img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc] - img[mr-2][mc-2] - 2*img[mr-1][mc-2] - img[mr][mc-2];
        gy = img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc] - img[mr-2][mc-2] - 2*img[mr-2][mc-1] - img[mr-2][mc];
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        x.e = mode ? ((m >= int'(threshold)) ? 8'hFF : 8'h00) : 8'(m);
        x.s = (mr == 2 && mc == 2);
        x.l = (mc == W - 1);
        x.t = cyc + 3;
        sb.push_back(x);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
  endtask
  task automatic frame(input int pat, input bit gaps, input bit sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) beat(0, 0, 0);
        beat(1, sof && r == 0 && c == 0, pix(pat, c));
      end
  endtask
  task automatic drain(input string tag, input int n);
    repeat (5) beat(0, 0, 0);
    chk({tag, "_count"}, rx - base, n);
    chk({tag, "_sb_left"}, sb.size(), 0);
    base = rx;
  endtask
  always @(negedge clk)
    if (out_valid) begin
      rx++;
      chk("out_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("edge", edge_out, x.e);
        chk("sof", out_sof, x.s);
        chk("eol", out_eol, x.l);
        chk("latency", cyc, x.t);
        last_e = edge_out;
      end
    end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_edge", edge_out, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eol", out_eol, 0);
    rst = 0;
    // 1: flat frame
    frame(0, 0, 1);
    drain("t1", 9);
    chk("t1_last", last_e, 8'h00);
    // 2: vertical step
    frame(1, 0, 1);
    drain("t2", 9);
    chk("t2_last", last_e, 8'h00);
    // 3: horizontal ramp, threshold at and just above Gx=80
    mode = 1;
    threshold = 80;
    frame(2, 0, 1);
    drain("t3a", 9);
    chk("t3a_last", last_e, 8'hFF);
    threshold = 81;
    frame(2, 0, 1);
    drain("t3b", 9);
    chk("t3b_last", last_e, 8'h00);
    mode = 0;
    // 4: step with alternate-cycle gaps
    frame(1, 1, 1);
    drain("t4", 9);
    // 5: reset after 12 beats, then a full frame
    for (int k = 0; k < 12; k++) beat(1, k == 0, pix(1, k % W));
    @(negedge clk);
    in_valid = 0;
    in_sof = 0;
    rst = 1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_edge", edge_out, 0);
    chk("t5_sb_at_rst", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("t5_hold_valid", out_valid, 0);
    rst = 0;
    mr = 0;
    mc = 0;
    base = rx;
    frame(1, 0, 1);
    drain("t5", 9);
    // 6: stray sof at beat 7, then two frames without sof
    for (int k = 0; k < 6; k++) beat(1, 0, pix(1, k % W));
    frame(1, 0, 1);
    frame(1, 0, 0);
    frame(1, 0, 0);
    drain("t6", 27);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
